// File: rtl/ovi_wb_pkg.sv
// rtl/ovi_wb_pkg.sv - Shared Wishbone cycle/burst types, slave states and burst address helper
package ovi_wb_pkg;

    localparam int SEL_W = 8;  // data bits covered by one byte select

    typedef enum logic [2:0] {
        CLASSIC = 3'b000,
        CONST   = 3'b001,
        INCR    = 3'b010,
        END     = 3'b111
    } cti_e;

    typedef enum logic [1:0] {
        LINEAR = 2'b00,
        WRAP4  = 2'b01,
        WRAP8  = 2'b10,
        WRAP16 = 2'b11
    } bte_e;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACK,
        BURST,
        TURN
    } slv_state_e;

    // Wrapping bursts only advance the low index bits and keep the aligned block.
    function automatic logic [31:0] next_burst_idx(input logic [31:0] idx, input bte_e bte);
        logic [31:0] inc;
        inc = idx + 32'd1;
        case (bte)
            WRAP4:   return {idx[31:2], inc[1:0]};
            WRAP8:   return {idx[31:3], inc[2:0]};
            WRAP16:  return {idx[31:4], inc[3:0]};
            default: return inc;
        endcase
    endfunction

endpackage

// File: rtl/ovi_wb_lfsr.sv
// rtl/ovi_wb_lfsr.sv - 16-bit Galois LFSR (taps 16,14,13,11) advanced on enable
module ovi_wb_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (en) begin
            state <= {1'b0, state[15:1]} ^ (state[0] ? 16'hB400 : 16'h0000);
        end
    end

endmodule

// File: rtl/ovi_wb_slave_mem.sv
// rtl/ovi_wb_slave_mem.sv - Wishbone B4 slave memory, random ack latency, bursts; OVI_WB_SLV_RTY_EN adds retry
module ovi_wb_slave_mem
    import ovi_wb_pkg::*;
#(
    parameter int          WB_ADDR_W = 32,
    parameter int          WB_DATA_W = 32,
    parameter int          DEPTH     = 1024,
    parameter int          DLY_W     = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                   wb_clk,
    input  logic                   wb_resetn,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    input  logic [WB_ADDR_W-1:0]   wb_adr_i,
    input  logic [WB_DATA_W-1:0]   wb_dat_i,
    input  logic [WB_DATA_W/8-1:0] wb_sel_i,
    input  logic [2:0]             wb_cti_i,
    input  logic [1:0]             wb_bte_i,
    output logic [WB_DATA_W-1:0]   wb_dat_o,
    output logic                   wb_ack_o,
    output logic                   wb_err_o,
    output logic                   wb_rty_o,
    input  logic [DLY_W-1:0]       cfg_ack_min,
    input  logic [DLY_W-1:0]       cfg_ack_max,
`ifdef OVI_WB_SLV_RTY_EN
    input  logic [3:0]             cfg_rty_n,
`endif
    output logic                   busy_o
);

    localparam int NSEL    = WB_DATA_W / SEL_W;
    localparam int IDX_LSB = $clog2(NSEL);
    localparam int IDX_W   = WB_ADDR_W - IDX_LSB;
    localparam int AW      = $clog2(DEPTH);

    slv_state_e           state;
    logic [IDX_W-1:0]     idx_q, req_idx, nxt_idx, ent_idx;
    logic                 we_q, ent_we, rty_pend_q, ent_rty, rty_hit;
    logic [2:0]           cti_q;
    bte_e                 bte_q;
    logic [DLY_W-1:0]     cnt, span, rnd, dly;
    logic                 ack_q, err_q, rty_q;
    logic [WB_DATA_W-1:0] dat_q, ent_dat;
    logic                 ent_oor, ent_ack, ent_err;
    logic [15:0]          lfsr;
    logic                 accept, done, cont, mem_we, term_ok;
    logic                 unused_bits;
    logic [WB_DATA_W-1:0] mem [DEPTH];

    assign req_idx = wb_adr_i[WB_ADDR_W-1:IDX_LSB];
    assign nxt_idx = IDX_W'(next_burst_idx(32'(idx_q), bte_q));
    assign accept  = (state == IDLE) && wb_cyc_i && wb_stb_i;
    assign done    = ((state == ACK) || (state == BURST)) && wb_cyc_i && wb_stb_i;
    assign mem_we  = done && ack_q && we_q;
    assign cont    = (state == ACK) ? (cti_q == INCR) : (wb_cti_i == INCR);

    // Wait states: min plus the LFSR draw saturated to the window; inverted window pins to min.
    assign span = cfg_ack_max - cfg_ack_min;
    assign rnd  = lfsr[DLY_W-1:0];
    assign dly  = (cfg_ack_max < cfg_ack_min) ? cfg_ack_min
                                              : cfg_ack_min + ((rnd > span) ? span : rnd);

    ovi_wb_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (wb_clk),
        .rst_n (wb_resetn),
        .en    (accept),
        .state (lfsr)
    );

`ifdef OVI_WB_SLV_RTY_EN
    logic [3:0] rty_cnt;

    assign rty_hit = (cfg_rty_n != 4'd0) && (wb_cti_i == CLASSIC) && (rty_cnt + 4'd1 == cfg_rty_n);

    always_ff @(posedge wb_clk or negedge wb_resetn) begin
        if (!wb_resetn) begin
            rty_cnt <= 4'd0;
        end else if (accept && (wb_cti_i == CLASSIC) && (cfg_rty_n != 4'd0)) begin
            rty_cnt <= rty_hit ? 4'd0 : rty_cnt + 4'd1;
        end
    end
`else
    assign rty_hit = 1'b0;
`endif

    // Beat about to be presented: new request from IDLE, held request from WAIT, next burst index otherwise.
    always_comb begin
        ent_idx = idx_q;
        ent_we  = we_q;
        ent_rty = rty_pend_q;
        if (state == IDLE) begin
            ent_idx = req_idx;
            ent_we  = wb_we_i;
            ent_rty = rty_hit;
        end else if ((state == ACK) || (state == BURST)) begin
            ent_idx = nxt_idx;
            ent_rty = 1'b0;
        end
    end

    assign ent_oor = (ent_idx >> AW) != '0;
    assign ent_ack = !ent_oor && !ent_rty;
    assign ent_err = ent_oor && !ent_rty;
    assign ent_dat = (ent_ack && !ent_we) ? mem[ent_idx[AW-1:0]] : '0;

    always_ff @(posedge wb_clk or negedge wb_resetn) begin
        if (!wb_resetn) begin
            state      <= IDLE;
            idx_q      <= '0;
            we_q       <= 1'b0;
            cti_q      <= 3'b000;
            bte_q      <= LINEAR;
            rty_pend_q <= 1'b0;
            cnt        <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rty_q      <= 1'b0;
            dat_q      <= '0;
        end else if (!wb_cyc_i) begin
            state <= IDLE;
            ack_q <= 1'b0;
            err_q <= 1'b0;
            rty_q <= 1'b0;
            dat_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wb_stb_i) begin
                        idx_q      <= req_idx;
                        we_q       <= wb_we_i;
                        cti_q      <= wb_cti_i;
                        bte_q      <= bte_e'(wb_bte_i);
                        rty_pend_q <= rty_hit;
                        if (dly == '0) begin
                            state <= ACK;
                            ack_q <= ent_ack;
                            err_q <= ent_err;
                            rty_q <= ent_rty;
                            dat_q <= ent_dat;
                        end else begin
                            cnt   <= dly;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == DLY_W'(1)) begin
                        state <= ACK;
                        ack_q <= ent_ack;
                        err_q <= ent_err;
                        rty_q <= ent_rty;
                        dat_q <= ent_dat;
                    end else begin
                        cnt <= cnt - DLY_W'(1);
                    end
                end
                ACK, BURST: begin
                    // stb low holds the pending beat; its termination stays masked until stb returns.
                    if (wb_stb_i) begin
                        if (cont && !rty_q) begin
                            state <= BURST;
                            idx_q <= nxt_idx;
                            ack_q <= ent_ack;
                            err_q <= ent_err;
                            rty_q <= 1'b0;
                            dat_q <= ent_dat;
                        end else begin
                            state <= TURN;
                            ack_q <= 1'b0;
                            err_q <= 1'b0;
                            rty_q <= 1'b0;
                            dat_q <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk) begin
        if (mem_we) begin
            for (int b = 0; b < NSEL; b++) begin
                if (wb_sel_i[b]) begin
                    mem[idx_q[AW-1:0]][SEL_W*b +: SEL_W] <= wb_dat_i[SEL_W*b +: SEL_W];
                end
            end
        end
    end

    assign term_ok     = wb_cyc_i && wb_stb_i;
    assign wb_ack_o    = ack_q && term_ok;
    assign wb_err_o    = err_q && term_ok;
    assign wb_rty_o    = rty_q && term_ok;
    assign wb_dat_o    = wb_ack_o ? dat_q : '0;
    assign busy_o      = (state != IDLE);
    assign unused_bits = ^{wb_adr_i, lfsr};

endmodule

// File: tb/tb_ovi_wb_slave_mem.sv
// tb/tb_ovi_wb_slave_mem.sv - Directed self-checking bench for ovi_wb_slave_mem
module tb_ovi_wb_slave_mem;

    logic        clk;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_w, dat_r;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack, err, rty, busy;
    logic [3:0]  cmin, cmax;

    int tests = 0;
    int fails = 0;
    int bad_term = 0;
    int busy_cycles = 0;

    logic [31:0] rd;
    int          lat;
    logic        ga, ge;
    logic [7:0]  seen;
    int          late_acks;

    int         widx [4] = '{6, 7, 4, 5};
    logic [2:0] wcti [4] = '{3'b010, 3'b010, 3'b010, 3'b111};

    ovi_wb_slave_mem dut (
        .wb_clk      (clk),
        .wb_resetn   (rst_n),
        .wb_cyc_i    (cyc),
        .wb_stb_i    (stb),
        .wb_we_i     (we),
        .wb_adr_i    (adr),
        .wb_dat_i    (dat_w),
        .wb_sel_i    (sel),
        .wb_cti_i    (cti),
        .wb_bte_i    (bte),
        .wb_dat_o    (dat_r),
        .wb_ack_o    (ack),
        .wb_err_o    (err),
        .wb_rty_o    (rty),
        .cfg_ack_min (cmin),
        .cfg_ack_max (cmax),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus-rule monitor: no termination without cyc&stb, one termination at a time, dat_o zero without ack.
    always @(negedge clk) begin
        if (rst_n) begin
            if ((ack || err || rty) && !(cyc && stb)) bad_term++;
            if ((32'(ack) + 32'(err) + 32'(rty)) > 32'd1) bad_term++;
            if (!ack && (dat_r !== 32'h0)) bad_term++;
            if (busy) busy_cycles++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        @(negedge clk);
        for (int w = 0; w < 32 && busy; w++) @(negedge clk);
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic classic(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rdat, output int l,
                           output logic got_ack, output logic got_err);
        wait_idle();
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s; cti = 3'b000; bte = 2'b00;
        l = 0; got_ack = 1'b0; got_err = 1'b0; rdat = 32'h0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack || err || rty) begin
                l = k; got_ack = ack; got_err = err; rdat = dat_r;
                break;
            end
        end
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'h0; dat_w = 32'h0;
        sel = 4'h0; cti = 3'b000; bte = 2'b00; cmin = 4'd0; cmax = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rty", 32'(rty), 32'd0);
        check("rst_dat", dat_r, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Zero-wait write then read with stb held into the turnaround cycle
        classic(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat, ga, ge);
        check("wr0_ack", 32'(ga), 32'd1);
        check("wr0_lat", 32'(lat), 32'd1);
        wait_idle();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h10; sel = 4'hF; cti = 3'b000; bte = 2'b00;
        @(posedge clk); @(negedge clk);
        check("rd0_ack", 32'(ack), 32'd1);
        check("rd0_dat", dat_r, 32'hDEADBEEF);
        @(posedge clk); @(negedge clk);
        check("turn_ack", 32'(ack), 32'd0);
        check("turn_busy", 32'(busy), 32'd1);
        @(posedge clk); @(negedge clk);
        check("turn_no_reaccept", 32'(busy), 32'd0);
        cyc = 1'b0; stb = 1'b0;

        // Fixed three wait states
        cmin = 4'd3; cmax = 4'd3;
        wait_idle();
        busy_cycles = 0;
        classic(1'b0, 32'h10, 32'h0, 4'hF, rd, lat, ga, ge);
        check("d3_lat", 32'(lat), 32'd4);
        check("d3_dat", rd, 32'hDEADBEEF);
        wait_idle();
        check("d3_busy_cycles", 32'(busy_cycles), 32'd5);

        // Inverted window falls back to the minimum
        cmin = 4'd3; cmax = 4'd1;
        classic(1'b0, 32'h10, 32'h0, 4'hF, rd, lat, ga, ge);
        check("inv_window_lat", 32'(lat), 32'd4);

        // Byte selects
        cmin = 4'd0; cmax = 4'd0;
        classic(1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, rd, lat, ga, ge);
        classic(1'b1, 32'h20, 32'h11223344, 4'b0101, rd, lat, ga, ge);
        classic(1'b0, 32'h20, 32'h0, 4'hF, rd, lat, ga, ge);
        check("sel_merge", rd, 32'hFF22FF44);

        // Wrap4 burst from index 6
        for (int i = 4; i < 8; i++) begin
            classic(1'b1, 32'(i * 4), 32'hA0A00000 + 32'(i), 4'hF, rd, lat, ga, ge);
        end
        wait_idle();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; bte = 2'b01; sel = 4'hF;
        adr = 32'(widx[0] * 4); cti = wcti[0];
        @(posedge clk);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            check($sformatf("wrap4_ack_%0d", b), 32'(ack), 32'd1);
            check($sformatf("wrap4_dat_%0d", b), dat_r, 32'hA0A00000 + 32'(widx[b]));
            @(posedge clk);
            #1;
            if (b < 3) begin
                adr = 32'(widx[b + 1] * 4); cti = wcti[b + 1];
            end
        end
        @(negedge clk);
        check("wrap4_end_ack", 32'(ack), 32'd0);
        cyc = 1'b0; stb = 1'b0; bte = 2'b00; cti = 3'b000;

        // Linear burst with a master wait state
        wait_idle();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h10; cti = 3'b010; bte = 2'b00;
        @(posedge clk); @(negedge clk);
        check("lin_b0_dat", dat_r, 32'hA0A00004);
        @(posedge clk); #1; stb = 1'b0;
        @(negedge clk);
        check("lin_gap_ack", 32'(ack), 32'd0);
        @(posedge clk); #1; stb = 1'b1; adr = 32'h14; cti = 3'b010;
        @(negedge clk);
        check("lin_b1_ack", 32'(ack), 32'd1);
        check("lin_b1_dat", dat_r, 32'hA0A00005);
        @(posedge clk); #1; adr = 32'h18; cti = 3'b111;
        @(negedge clk);
        check("lin_b2_dat", dat_r, 32'hA0A00006);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; cti = 3'b000;

        // Out-of-range write errors and leaves the aliased word alone
        classic(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, lat, ga, ge);
        classic(1'b1, 32'h1000, 32'h12345678, 4'hF, rd, lat, ga, ge);
        check("oor_err", 32'(ge), 32'd1);
        check("oor_no_ack", 32'(ga), 32'd0);
        check("oor_dat", rd, 32'h0);
        classic(1'b0, 32'h0, 32'h0, 4'hF, rd, lat, ga, ge);
        check("oor_mem_kept", rd, 32'hCAFEF00D);

        // Random latency window 1..5
        cmin = 4'd1; cmax = 4'd5; seen = 8'h0;
        for (int i = 0; i < 200; i++) begin
            classic(1'b0, 32'($urandom_range(0, 1023)) << 2, 32'h0, 4'hF, rd, lat, ga, ge);
            check("rand_lat_range", 32'((lat >= 2) && (lat <= 6)), 32'd1);
            if ((lat >= 2) && (lat <= 6)) seen[lat] = 1'b1;
        end
        check("rand_lat_all_seen", 32'(seen[6:2]), 32'h1F);

        // Abort during WAIT
        cmin = 4'd5; cmax = 4'd5;
        wait_idle();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h10; cti = 3'b000;
        @(posedge clk); @(negedge clk);
        check("abort_busy_wait", 32'(busy), 32'd1);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); @(negedge clk);
        check("abort_idle", 32'(busy), 32'd0);
        late_acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack || err) late_acks++;
        end
        check("abort_no_ack", 32'(late_acks), 32'd0);

        // Reset in the middle of a burst
        cmin = 4'd0; cmax = 4'd0;
        wait_idle();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; cti = 3'b010; bte = 2'b00;
        @(posedge clk); @(negedge clk);
        check("rstb_ack_before", 32'(ack), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstb_ack", 32'(ack), 32'd0);
        check("rstb_dat", dat_r, 32'h0);
        check("rstb_busy", 32'(busy), 32'd0);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; cti = 3'b000;
        rst_n = 1'b1;
        wait_idle();

        check("bus_rules", 32'(bad_term), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ovi_wb_slave_mem.md
Name: ovi_wb_slave_mem

Overview:
Parametrised Wishbone B4 slave responder with internal word-addressed memory. Runtime-programmable random ack latency (min/max window) and registered-feedback bursts (CTI/BTE linear and wrap). Out-of-range addresses return ERR. Sits behind the ovi_wishbone interface as a synthesizable memory model and bench target, replacing ad-hoc delay functions with RTL behaviour.

Parameters:
WB_ADDR_W, 32, byte address width
WB_DATA_W, 32, data width; multiple of 8
DEPTH, 1024, memory depth in words; power of two
DLY_W, 4, width of delay config and counter
LFSR_SEED, 16'hACE1, reset seed of 16-bit delay LFSR

Ports:
wb_clk  in  1  clock
wb_resetn  in  1  asynchronous active-low reset
wb_cyc_i  in  1  cycle valid
wb_stb_i  in  1  strobe
wb_we_i  in  1  write enable
wb_adr_i  in  WB_ADDR_W  byte address
wb_dat_i  in  WB_DATA_W  write data
wb_sel_i  in  WB_DATA_W/8  byte selects
wb_cti_i  in  3  cycle type (000 classic, 010 incr burst, 111 end)
wb_bte_i  in  2  burst type (00 linear, 01 wrap4, 10 wrap8, 11 wrap16)
wb_dat_o  out  WB_DATA_W  read data, valid with ack
wb_ack_o  out  1  normal termination
wb_err_o  out  1  error termination
wb_rty_o  out  1  retry termination
cfg_ack_min  in  DLY_W  minimum wait states
cfg_ack_max  in  DLY_W  maximum wait states
busy_o  out  1  high when state != IDLE

Behaviour:
- Reset: wb_ack_o/err_o/rty_o=0, wb_dat_o=0, busy_o=0, state IDLE, LFSR=LFSR_SEED. Memory contents not reset.
- Word index = wb_adr_i[WB_ADDR_W-1:log2(WB_DATA_W/8)]. An index >= DEPTH is out of range.
- States: IDLE, WAIT, ACK, BURST, TURN.
- IDLE: on an edge with cyc&stb, latch adr/we/cti/bte. Compute d = min + sat(r, span), where r = LFSR[DLY_W-1:0] and span = max-min. If max < min, d = min. LFSR advances once per accepted request. If d=0, go to ACK; else load counter with d and go to WAIT.
- WAIT: decrement each cycle; go to ACK when counter reaches 1. Latency is d+1 cycles from the stb sample edge to the ack cycle.
- ACK: exactly one of ack/err is high for one cycle. Reads drive mem[idx] on wb_dat_o. Writes update bytes where sel=1 at the ack edge. On ERR, memory is unchanged and wb_dat_o=0.
  - If latched cti=010 and stb is still high, go to BURST.
  - Otherwise go to TURN. TURN is one idle cycle so the stb held during the ack cycle is not re-accepted.
- BURST: ack (or err per beat) asserted every cycle while stb=1 (zero wait). The address advances each beat: linear +1 word; wrap4/8/16 increments the low 2/3/4 index bits only. stb=0 inserts a wait (no ack). The beat with cti=111 is the final ack, then TURN. cti=000 during a burst ends it after the current beat.
- cyc=0 in any state: abort to IDLE next cycle. No ack, no write, outputs 0 in that cycle.
- wb_dat_o=0 whenever ack is low.
- ack, err and rty are mutually exclusive and never high with cyc=0 at the preceding edge.

Optional Feature:
OVI_WB_SLV_RTY_EN:
- Adds port cfg_rty_n (in, 4). When nonzero, every cfg_rty_n-th accepted classic request terminates with wb_rty_o instead of ack: no write, then TURN. The request counter resets to 0 on reset.
- Without the macro: port absent, wb_rty_o tied 0.

Decomposition:
- Package ovi_wb_pkg holds:
  - cti_e (CLASSIC, CONST, INCR, END)
  - bte_e (LINEAR, WRAP4, WRAP8, WRAP16)
  - slv_state_e
  - function next_burst_idx(idx, bte)
  - localparam SEL_W
- Sub-module ovi_wb_lfsr: 16-bit Galois LFSR (taps 16,14,13,11), with seed parameter and advance enable.

Test Plan:
- cfg_ack_min=max=0; classic write 0xDEADBEEF to 0x10, sel=4'hF; read 0x10 -> ack 1 cycle after stb, dat_o=0xDEADBEEF, then one TURN cycle.
- min=max=3; classic read -> ack exactly 4 cycles after the stb edge; busy_o high for 4 cycles plus TURN.
- min=1, max=5; 200 random reads -> every latency in [2,6], all values 2..6 observed, no ack with stb low.
- Write sel=4'b0101 data 0x11223344 over 0xFFFFFFFF -> read returns 0xFF22FF44.
- Wrap4 burst read from index 6 (cti 010,010,010,111) -> acks on consecutive cycles for indices 6,7,4,5; ack low after the 111 beat.
- Address DEPTH*4 -> err for 1 cycle, ack=0, memory unchanged. Drop cyc in WAIT -> no ack, IDLE next cycle. Assert reset mid-burst -> all outputs 0 immediately.
